encode83_irq: RTL and testbench

- Sequential 8-to-3 priority encoder; the counterpart of the team's 3-to-8 active-low decoder.
- Captures assertion events on eight active-low request lines, queues each event as a pending bit, and presents the highest-priority pending index as a 3-bit binary code.
- The code is presented under a valid/ack handshake and is directly consumable by the decoder's A2..A0 inputs.
- Sits between asynchronous request sources (buttons, interrupt lines) and a synchronous consumer.

---
 rtl/encode83_irq_if.sv | 43 ++++
 rtl/encode83_irq.sv | 167 ++++++++++++++++
 tb/tb_encode83_irq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/encode83_irq_if.sv
// encode83_irq_if: request lines, enable and valid/ack code handshake of the
// encode83_irq sequential priority encoder, plus debug visibility of its state.
//
// Handshake: the encoder raises valid together with a stable code on A2..A0
// and holds both until the consumer asserts ack on a rising clock edge while
// valid=1; that edge completes the transfer and drops valid. ack while valid=0
// has no effect.
interface encode83_irq_if;
  // Asynchronous active-low request lines, I7 highest fixed priority
  logic       I0;
  logic       I1;
  logic       I2;
  logic       I3;
  logic       I4;
  logic       I5;
  logic       I6;
  logic       I7;
  // Enable (active-low) and consumer acknowledge
  logic       EI_n;
  logic       ack;
  // Presented code and status
  logic       A2;
  logic       A1;
  logic       A0;
  logic       valid;
  logic       GS_n;
  logic       EO_n;
  // Debug: FSM state (0=IDLE, 1=PRESENT) and the pending event set
  logic       dbg_state;
  logic [7:0] dbg_pending;

  // Request source / consumer side
  modport master (
    output I0, I1, I2, I3, I4, I5, I6, I7, EI_n, ack,
    input  A2, A1, A0, valid, GS_n, EO_n, dbg_state, dbg_pending
  );

  // Encoder side
  modport slave (
    input  I0, I1, I2, I3, I4, I5, I6, I7, EI_n, ack,
    output A2, A1, A0, valid, GS_n, EO_n, dbg_state, dbg_pending
  );
endinterface

// File: rtl/encode83_irq.sv
// encode83_irq: sequential 8-to-3 priority encoder with edge-captured pending
// requests and a valid/ack presentation handshake.
// Optional macro ENC83_ROTATE_PRIO_EN: round-robin search starting below the
// last granted code; when undefined, fixed priority (I7 highest).
module encode83_irq #(
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  encode83_irq_if.slave bus
);

  // Fewer than two stages would not be a synchronizer; clamp defensively.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  logic [7:0]              w_req_n;
  logic [STAGES-1:0][7:0]  r_sync;
  logic [7:0]              r_prev;
  logic [7:0]              w_event;
  logic [7:0]              r_pending;
  logic [7:0]              w_clr;
  state_t                  r_state;
  state_t                  w_state_next;
  logic [2:0]              r_code;
  logic                    w_load;
  logic                    w_handshake;
  logic                    r_gs_n;
  logic                    r_eo_n;
  logic [2:0]              w_base;
  logic                    w_found;
  logic [2:0]              w_idx;
  logic [2:0]              w_cand;

  assign w_req_n = {bus.I7, bus.I6, bus.I5, bus.I4,
                    bus.I3, bus.I2, bus.I1, bus.I0};

  // Synchronizer chain and previous-sample flop; idle level of every line is 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_prev <= '1;
    end else begin
      r_sync[0] <= w_req_n;
      for (int s = 1; s < STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_prev <= r_sync[STAGES-1];
    end
  end

  // A falling edge of the synchronized line is one assertion event
  assign w_event = r_prev & ~r_sync[STAGES-1];

  // Pending set: a new event wins over a same-cycle clear of the same bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 8'h00;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_event;
    end
  end

`ifdef ENC83_ROTATE_PRIO_EN
  logic [2:0] r_last_grant;

  // Remember the most recently handed-over code for the rotating search
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 3'd0;
    end else if (w_handshake) begin
      r_last_grant <= r_code;
    end
  end

  assign w_base = r_last_grant;
`else
  // Base 0 makes the search order 7,6,...,0: plain fixed priority
  assign w_base = 3'd0;
`endif

  // Search base-1, base-2, ... base (mod 8) and take the first pending bit
  always_comb begin
    w_found = 1'b0;
    w_idx   = 3'd0;
    w_cand  = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      w_cand = w_base - i[2:0];
      if (!w_found && r_pending[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: present only when enabled; leave PRESENT on ack
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (!bus.EI_n && w_found) w_state_next = S_PRESENT;
      S_PRESENT: if (bus.ack)              w_state_next = S_IDLE;
      default:                             w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs: code load strobe and pending-clear mask on handshake
  always_comb begin
    w_load      = 1'b0;
    w_handshake = 1'b0;
    w_clr       = 8'h00;
    case (r_state)
      S_IDLE: begin
        w_load = !bus.EI_n && w_found;
      end
      S_PRESENT: begin
        w_handshake = bus.ack;
        if (bus.ack) w_clr = 8'h01 << r_code;
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  // Code register: loaded on entry to PRESENT, held stable until the next load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code <= 3'b000;
    end else if (w_load) begin
      r_code <= w_idx;
    end
  end

  // Group-select / enable-out status, re-evaluated every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gs_n <= 1'b1;
      r_eo_n <= 1'b1;
    end else begin
      r_gs_n <= !(!bus.EI_n && (r_pending != 8'h00));
      r_eo_n <= !(!bus.EI_n && (r_pending == 8'h00));
    end
  end

  assign bus.A2          = r_code[2];
  assign bus.A1          = r_code[1];
  assign bus.A0          = r_code[0];
  assign bus.valid       = (r_state == S_PRESENT);
  assign bus.GS_n        = r_gs_n;
  assign bus.EO_n        = r_eo_n;
  assign bus.dbg_state   = r_state;
  assign bus.dbg_pending = r_pending;

endmodule

// File: tb/tb_encode83_irq.sv
// tb_encode83_irq: directed bench for encode83_irq with hand-computed codes.
module tb_encode83_irq;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_n;
  int         n_total;
  int         n_bad;

  encode83_irq_if bus ();

  assign bus.I0 = req_n[0];
  assign bus.I1 = req_n[1];
  assign bus.I2 = req_n[2];
  assign bus.I3 = req_n[3];
  assign bus.I4 = req_n[4];
  assign bus.I5 = req_n[5];
  assign bus.I6 = req_n[6];
  assign bus.I7 = req_n[7];

  encode83_irq #(.SYNC_STAGES(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking task
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past a rising edge; sample and drive 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [2:0] code();
    return {bus.A2, bus.A1, bus.A0};
  endfunction

  // Bounded wait for valid; expiry is a failed comparison
  task automatic wait_valid(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!bus.valid && n < max_cyc) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {31'd0, bus.valid}, 32'd1);
  endtask

  // One-cycle ack pulse; returns 1 ns after the ack edge
  task automatic pulse_ack();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  int seen;

  initial begin
    n_total  = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    req_n    = 8'hFF;
    bus.EI_n = 1'b0;
    bus.ack  = 1'b0;

    // Reset state
    ticks(2);
    chk("rst_valid", {31'd0, bus.valid}, 32'd0);
    chk("rst_code", {29'd0, code()}, 32'd0);
    chk("rst_gs", {31'd0, bus.GS_n}, 32'd1);
    chk("rst_eo", {31'd0, bus.EO_n}, 32'd1);
    chk("rst_pend", {24'd0, bus.dbg_pending}, 32'd0);
    rst_n = 1'b1;
    ticks(3);
    chk("idle_eo", {31'd0, bus.EO_n}, 32'd0);
    chk("idle_gs", {31'd0, bus.GS_n}, 32'd1);

    // Single request on I3: exact latency
    req_n[3] = 1'b0;          // falls before E0
    ticks(3);                  // E0..E2
    chk("single_pend", {24'd0, bus.dbg_pending}, 32'h08);
    chk("single_early", {31'd0, bus.valid}, 32'd0);
    tick();                    // E3
    chk("single_valid", {31'd0, bus.valid}, 32'd1);
    chk("single_code", {29'd0, code()}, 32'd3);
    chk("single_gs", {31'd0, bus.GS_n}, 32'd0);
    pulse_ack();
    chk("single_drop", {31'd0, bus.valid}, 32'd0);
    chk("single_eo_lag", {31'd0, bus.EO_n}, 32'd1);
    tick();
    chk("single_eo", {31'd0, bus.EO_n}, 32'd0);
    req_n[3] = 1'b1;
    ticks(4);

    // Reset asserted mid-PRESENT with code 5
    req_n[5] = 1'b0;
    wait_valid("rst5", 8);
    chk("rst5_code", {29'd0, code()}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("rst5_valid", {31'd0, bus.valid}, 32'd0);
    chk("rst5_code0", {29'd0, code()}, 32'd0);
    chk("rst5_gs", {31'd0, bus.GS_n}, 32'd1);
    chk("rst5_eo", {31'd0, bus.EO_n}, 32'd1);
    chk("rst5_pend", {24'd0, bus.dbg_pending}, 32'd0);
    req_n[5] = 1'b1;
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.valid) seen++;
    end
    chk("rst5_quiet", seen, 0);

    // Simultaneous I1, I4, I6; I7 arrives while 4 is being presented
    req_n[1] = 1'b0;
    req_n[4] = 1'b0;
    req_n[6] = 1'b0;
    wait_valid("sim_a", 8);
    chk("sim_a_code", {29'd0, code()}, 32'd6);
    ticks(3);
    chk("sim_a_hold", {28'd0, bus.valid, code()}, 32'hE);
    pulse_ack();
    chk("sim_a_idle", {31'd0, bus.valid}, 32'd0);
    wait_valid("sim_b", 4);
    chk("sim_b_code", {29'd0, code()}, 32'd4);
    req_n[7] = 1'b0;
    ticks(5);
    chk("sim_b_hold", {28'd0, bus.valid, code()}, 32'hC);
    chk("sim_pend", {24'd0, bus.dbg_pending}, 32'h92);
    pulse_ack();
    chk("sim_b_idle", {31'd0, bus.valid}, 32'd0);
    wait_valid("sim_c", 4);
`ifdef ENC83_ROTATE_PRIO_EN
    chk("sim_c_code", {29'd0, code()}, 32'd1);
`else
    chk("sim_c_code", {29'd0, code()}, 32'd7);
`endif
    pulse_ack();
    chk("sim_c_idle", {31'd0, bus.valid}, 32'd0);
    wait_valid("sim_d", 4);
`ifdef ENC83_ROTATE_PRIO_EN
    chk("sim_d_code", {29'd0, code()}, 32'd7);
`else
    chk("sim_d_code", {29'd0, code()}, 32'd1);
`endif
    pulse_ack();
    chk("sim_pend_empty", {24'd0, bus.dbg_pending}, 32'd0);
    req_n = 8'hFF;
    ticks(4);

    // Set/clear collision on I2
    req_n[2] = 1'b0;
    wait_valid("col", 8);
    chk("col_code", {29'd0, code()}, 32'd2);
    req_n[2] = 1'b1;           // after P0
    ticks(2);                  // P1, P2
    req_n[2] = 1'b0;           // after P2
    ticks(2);                  // P3, P4: event now asserted
    pulse_ack();               // P5: set and clear collide
    chk("col_drop", {31'd0, bus.valid}, 32'd0);
    chk("col_pend", {24'd0, bus.dbg_pending}, 32'h04);
    tick();                    // P6
    chk("col_repr", {28'd0, bus.valid, code()}, 32'hA);
    pulse_ack();
    req_n[2] = 1'b1;
    ticks(4);

    // Enable gating with I0; ack in IDLE is ignored
    bus.EI_n = 1'b1;
    req_n[0] = 1'b0;
    ticks(5);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("en_valid", {31'd0, bus.valid}, 32'd0);
    chk("en_gs", {31'd0, bus.GS_n}, 32'd1);
    chk("en_eo", {31'd0, bus.EO_n}, 32'd1);
    chk("en_pend", {24'd0, bus.dbg_pending}, 32'h01);
    bus.EI_n = 1'b0;
    wait_valid("en", 2);
    chk("en_code", {29'd0, code()}, 32'd0);
    pulse_ack();
    req_n[0] = 1'b1;
    ticks(4);

    // Held line I5: exactly one presentation
    req_n[5] = 1'b0;
    wait_valid("held", 8);
    chk("held_code", {29'd0, code()}, 32'd5);
    pulse_ack();
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.valid) seen++;
    end
    chk("held_once", seen, 0);
    chk("held_pend", {24'd0, bus.dbg_pending}, 32'd0);
    req_n[5] = 1'b1;
    ticks(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
